// File: rtl/ram_dp_param.sv
// Parametrised true dual-port RAM: read-first registered ports, write-collision arbitration, post-reset zero fill.
// Optional macro RAM_PARITY_EN adds one stored even-parity bit per word and perr_a/perr_b outputs.
module ram_dp_param #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 15,
  parameter int COLL_WINNER = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              valid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              valid_b,
`ifdef RAM_PARITY_EN
  output logic              perr_a,
  output logic              perr_b,
`endif
  output logic              init_busy,
  output logic              collision
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_FILL, S_READY} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy;
  logic [MEM_W-1:0]    r_mem [DEPTH];

  logic [DATA_W-1:0]   r_dout_a_p1;
  logic [DATA_W-1:0]   r_dout_b_p1;
  logic                r_vld_a_p1;
  logic                r_vld_b_p1;
  logic                r_coll_p1;

  logic                w_fill_we;
  logic                w_acc_a;
  logic                w_acc_b;
  logic                w_wr_a;
  logic                w_wr_b;
  logic                w_coll;
  logic                w_do_a;
  logic                w_do_b;
  logic [MEM_W-1:0]    w_wd_a;
  logic [MEM_W-1:0]    w_wd_b;
  logic [MEM_W-1:0]    w_rd_a;
  logic [MEM_W-1:0]    w_rd_b;

`ifdef RAM_PARITY_EN
  logic                r_perr_a_p1;
  logic                r_perr_b_p1;

  function automatic logic f_even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign w_wd_a = {f_even_par(din_a), din_a};
  assign w_wd_b = {f_even_par(din_b), din_b};
`else
  assign w_wd_a = din_a;
  assign w_wd_b = din_b;
`endif

  // Reset dominates: no fill and no port access on a reset edge.
  assign w_fill_we = rst_n && (r_state == S_FILL);
  assign w_acc_a   = rst_n && (r_state == S_READY) && en_a;
  assign w_acc_b   = rst_n && (r_state == S_READY) && en_b;
  assign w_wr_a    = w_acc_a && we_a;
  assign w_wr_b    = w_acc_b && we_b;
  assign w_coll    = w_wr_a && w_wr_b && (addr_a == addr_b);
  assign w_do_a    = w_wr_a && !(w_coll && (COLL_WINNER != 0));
  assign w_do_b    = w_wr_b && !(w_coll && (COLL_WINNER == 0));

  assign w_rd_a = r_mem[addr_a];
  assign w_rd_b = r_mem[addr_b];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (w_fill_we) r_mem[r_ptr] <= '0;
    if (w_do_a)    r_mem[addr_a] <= w_wd_a;
    if (w_do_b)    r_mem[addr_b] <= w_wd_b;
  end

  // Stage p1: control FSM and registered read-first outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_ptr       <= '0;
      r_busy      <= 1'b1;
      r_vld_a_p1  <= 1'b0;
      r_vld_b_p1  <= 1'b0;
      r_coll_p1   <= 1'b0;
      r_dout_a_p1 <= '0;
      r_dout_b_p1 <= '0;
`ifdef RAM_PARITY_EN
      r_perr_a_p1 <= 1'b0;
      r_perr_b_p1 <= 1'b0;
`endif
    end else begin
      r_vld_a_p1 <= w_acc_a;
      r_vld_b_p1 <= w_acc_b;
      r_coll_p1  <= w_coll;
      if (w_acc_a) r_dout_a_p1 <= w_rd_a[DATA_W-1:0];
      if (w_acc_b) r_dout_b_p1 <= w_rd_b[DATA_W-1:0];
`ifdef RAM_PARITY_EN
      r_perr_a_p1 <= w_acc_a && (w_rd_a[DATA_W] != f_even_par(w_rd_a[DATA_W-1:0]));
      r_perr_b_p1 <= w_acc_b && (w_rd_b[DATA_W] != f_even_par(w_rd_b[DATA_W-1:0]));
`endif
      case (r_state)
        S_FILL: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST_ADDR) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        S_READY: r_state <= S_READY;
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign dout_a    = r_dout_a_p1;
  assign dout_b    = r_dout_b_p1;
  assign valid_a   = r_vld_a_p1;
  assign valid_b   = r_vld_b_p1;
  assign collision = r_coll_p1;
  assign init_busy = r_busy;
`ifdef RAM_PARITY_EN
  assign perr_a    = r_perr_a_p1;
  assign perr_b    = r_perr_b_p1;
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two instances (port-A and port-B collision winner) driven identically,
// compared every cycle against an array-based transaction model. Honours RAM_PARITY_EN.
module tb_ram_dp_param;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;

  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic          valid_a0, valid_b0, valid_a1, valid_b1;
  logic          busy0, busy1, coll0, coll1;
`ifdef RAM_PARITY_EN
  logic          perr_a0, perr_b0, perr_a1, perr_b1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_mem [2][DEPTH];
  bit m_bad [2][DEPTH];
  int m_da [2], m_db [2];
  bit m_va [2], m_vb [2], m_pa [2], m_pb [2];
  bit m_coll, m_busy, m_ready;
  int m_ptr;

  always #5 clk = ~clk;

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .COLL_WINNER(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .valid_a(valid_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .valid_b(valid_b0),
`ifdef RAM_PARITY_EN
    .perr_a(perr_a0), .perr_b(perr_b0),
`endif
    .init_busy(busy0), .collision(coll0));

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .COLL_WINNER(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .valid_a(valid_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .valid_b(valid_b1),
`ifdef RAM_PARITY_EN
    .perr_a(perr_a1), .perr_b(perr_b1),
`endif
    .init_busy(busy1), .collision(coll1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int oa, ob;
    bit wa, wb;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_da[i] = 0; m_db[i] = 0; m_va[i] = 0; m_vb[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
      end
      m_coll = 0; m_busy = 1; m_ready = 0; m_ptr = 0;
    end else if (!m_ready) begin
      for (int i = 0; i < 2; i++) begin
        m_mem[i][m_ptr] = 0; m_bad[i][m_ptr] = 0;
        m_va[i] = 0; m_vb[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
      end
      m_coll = 0;
      if (m_ptr == DEPTH - 1) begin m_ready = 1; m_busy = 0; end
      else m_ptr++;
    end else begin
      wa = en_a && we_a;
      wb = en_b && we_b;
      m_coll = wa && wb && (addr_a == addr_b);
      for (int i = 0; i < 2; i++) begin
        oa = m_mem[i][addr_a];
        ob = m_mem[i][addr_b];
        m_va[i] = en_a; m_vb[i] = en_b;
        m_pa[i] = en_a && m_bad[i][addr_a];
        m_pb[i] = en_b && m_bad[i][addr_b];
        if (en_a) m_da[i] = oa;
        if (en_b) m_db[i] = ob;
        if (m_coll) begin
          m_mem[i][addr_a] = (i == 0) ? int'(din_a) : int'(din_b);
          m_bad[i][addr_a] = 0;
        end else begin
          if (wa) begin m_mem[i][addr_a] = din_a; m_bad[i][addr_a] = 0; end
          if (wb) begin m_mem[i][addr_b] = din_b; m_bad[i][addr_b] = 0; end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("dout_a0", dout_a0, m_da[0]);   chk("dout_b0", dout_b0, m_db[0]);
    chk("valid_a0", valid_a0, m_va[0]); chk("valid_b0", valid_b0, m_vb[0]);
    chk("dout_a1", dout_a1, m_da[1]);   chk("dout_b1", dout_b1, m_db[1]);
    chk("valid_a1", valid_a1, m_va[1]); chk("valid_b1", valid_b1, m_vb[1]);
    chk("busy0", busy0, m_busy);        chk("busy1", busy1, m_busy);
    chk("coll0", coll0, m_coll);        chk("coll1", coll1, m_coll);
`ifdef RAM_PARITY_EN
    chk("perr_a0", perr_a0, m_pa[0]);   chk("perr_b0", perr_b0, m_pb[0]);
    chk("perr_a1", perr_a1, m_pa[1]);   chk("perr_b1", perr_b1, m_pb[1]);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
  endtask

  task automatic wait_fill(input string tag);
    int cnt = 0;
    while (busy0 && cnt < 100) begin
      en_a = 1; we_a = 1; din_a = 4'hF; addr_a = AW'($urandom_range(0, DEPTH - 1));
      en_b = 1; we_b = 1; din_b = 4'hF; addr_b = AW'($urandom_range(0, DEPTH - 1));
      cycle();
      cnt++;
    end
    chk(tag, cnt, DEPTH);
    idle();
  endtask

  initial begin
    rst_n = 0;
    cycle();
    cycle();
    chk("rst_busy", busy0, 1);
    chk("rst_dout", dout_a0, 0);

    // Release; writes attempted during fill must be dropped
    rst_n = 1;
    wait_fill("busy_len");

    for (int i = 0; i < DEPTH; i++) begin
      en_a = 1; we_a = 0; addr_a = AW'(i);
      cycle();
      chk("fill_zero", dout_a0, 0);
      chk("fill_vld", valid_a0, 1);
    end
    idle();
    cycle();
    chk("vld_drop", valid_a0, 0);

    en_a = 1; we_a = 1; addr_a = 3; din_a = 4'hA;
    cycle();
    chk("wr_old", dout_a0, 0);
    idle(); en_b = 1; addr_b = 3;
    cycle();
    chk("rd_b3", dout_b0, 4'hA);

    en_a = 1; we_a = 1; addr_a = 7; din_a = 4'h5;
    en_b = 1; we_b = 1; addr_b = 7; din_b = 4'hC;
    cycle();
    chk("coll_pulse", coll0, 1);
    idle();
    cycle();
    chk("coll_clear", coll0, 0);
    en_a = 1; addr_a = 7;
    cycle();
    chk("coll_win_a", dout_a0, 4'h5);
    chk("coll_win_b", dout_a1, 4'hC);

    idle(); en_a = 1; we_a = 1; addr_a = 2; din_a = 4'h1;
    cycle();
    en_a = 1; we_a = 1; addr_a = 2; din_a = 4'h9;
    en_b = 1; we_b = 0; addr_b = 2;
    cycle();
    chk("rfw_old", dout_b0, 4'h1);
    chk("rfw_nocoll", coll0, 0);
    idle(); en_b = 1; addr_b = 2;
    cycle();
    chk("rfw_new", dout_b0, 4'h9);

`ifdef RAM_PARITY_EN
    idle();
    u0.r_mem[5][0] = ~u0.r_mem[5][0];
    m_mem[0][5] = m_mem[0][5] ^ 1;
    m_bad[0][5] = 1;
    en_a = 1; addr_a = 5;
    cycle();
    chk("perr_hit", perr_a0, 1);
    chk("perr_vld", valid_a0, 1);
    addr_a = 6;
    cycle();
    chk("perr_clean", perr_a0, 0);
    idle();
`endif

    // Randomised traffic over a narrow address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      en_a = 1'($urandom); we_a = 1'($urandom); addr_a = AW'($urandom_range(0, 3)); din_a = DW'($urandom);
      en_b = 1'($urandom); we_b = 1'($urandom); addr_b = AW'($urandom_range(0, 3)); din_b = DW'($urandom);
      if (n % 7 == 0) addr_b = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle();

    // Reset during fill at pointer 8
    rst_n = 0;
    cycle();
    rst_n = 1;
    for (int i = 0; i < 8; i++) cycle();
    rst_n = 0;
    cycle();
    chk("midfill_busy", busy0, 1);
    chk("midfill_dout", dout_b0, 0);
    rst_n = 1;
    wait_fill("busy_len2");
    for (int i = 0; i < DEPTH; i++) begin
      en_a = 1; addr_a = AW'(i); en_b = 1; addr_b = AW'(DEPTH - 1 - i);
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised true dual-port synchronous RAM; next generation of the 32Kx4 dual-port memory. Generalised width/depth, registered (1-cycle) reads on both ports, deterministic write-collision arbitration with a flag, and a hardware zero-fill sequencer after reset. Shared memory macro for buffers and tables on a single clock domain.

Parameters:
DATA_W, 4, word width in bits
ADDR_W, 15, address width; DEPTH = 2**ADDR_W words
COLL_WINNER, 0, same-address write collision winner: 0 = port A, 1 = port B

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
en_a  input  1  port A access enable
we_a  input  1  port A write (valid only with en_a)
addr_a  input  ADDR_W  port A address
din_a  input  DATA_W  port A write data
dout_a  output  DATA_W  port A registered read data
valid_a  output  1  dout_a updated this cycle
en_b, we_b, addr_b, din_b, dout_b, valid_b  same as port A, for port B
init_busy  output  1  zero-fill in progress; port requests ignored
collision  output  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset (rst_n=0 at edge): dout_a/dout_b=0, valid_a/valid_b=0, collision=0, init_busy=1, fill pointer=0, FSM -> FILL. Memory contents not cleared by reset itself.
- FSM states: FILL, READY.
- FILL: each cycle write 0 to mem[ptr], ptr++; init_busy=1; en_a/en_b ignored (no writes, valid_x=0, dout_x hold 0). After writing DEPTH-1 -> READY next cycle; init_busy falls on the edge that writes DEPTH-1, so init_busy is high exactly DEPTH cycles after reset release.
- Reset asserted mid-FILL or in READY: restart FILL from address 0.
- READY, per port x, at edge with en_x=1:
  - we_x=0: dout_x <= mem[addr_x]; valid_x=1 next cycle (latency 1).
  - we_x=1: mem[addr_x] <= din_x; dout_x <= old mem[addr_x] (read-first); valid_x=1 next cycle.
  - en_x=0: dout_x holds, valid_x=0.
- Simultaneous events, same address, both enabled:
  - both write: only COLL_WINNER port data stored; collision=1 for one cycle; both dout return old word.
  - one write, one read: reader gets old word (read-first); new word visible next access; collision=0.
  - both read: both get same word; collision=0.
- Different addresses: fully independent, no interaction.
- Address is always in range (DEPTH = 2**ADDR_W); no wrap logic needed beyond fill pointer terminating at DEPTH-1.

Optional Feature:
RAM_PARITY_EN: when defined, each word stores one extra even-parity bit computed from din on write (and 0 during FILL, correct for zero data). Adds outputs perr_a, perr_b (1 bit), asserted with valid_x when stored parity mismatches recomputed parity of read word; reset 0. Without the macro: no parity storage, no perr ports, memory exactly DATA_W wide.

Test Plan:
- ADDR_W=4: release reset -> init_busy high exactly 16 cycles; en_a/we_a writes of 0xF during fill not stored; afterwards read all 16 addresses on A -> all 0x0, valid_a one cycle after each en_a.
- Write A addr 3 = 0xA, next cycle read B addr 3 -> dout_b=0xA one cycle later; write port dout_a returned old 0x0.
- Same cycle A writes 0x5, B writes 0xC to addr 7, COLL_WINNER=0 -> collision pulse 1 cycle, later read -> 0x5; rerun COLL_WINNER=1 -> 0xC.
- Same cycle A writes 0x9 to addr 2 (holding 0x1), B reads addr 2 -> dout_b=0x1, collision=0; next B read -> 0x9.
- Assert rst_n=0 for one cycle at fill pointer 8 -> outputs zero, fill restarts, init_busy high 16 more cycles.
- RAM_PARITY_EN: force-flip one stored bit at addr 5 via backdoor, read on A -> perr_a=1 with valid_a; clean address -> perr_a=0.
